// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC and fetches one instruction at a time over req/gnt/rvalid.
// Optional build macro MISALIGN_TRAP_EN: trap misaligned new_pc on commit instead of masking.
module fetch_unit #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic [31:0] pc_plus_4,
    input  logic [31:0] new_pc,
    output logic        fetch_err,
    output logic        fetch_misaligned
);

    localparam int CW_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CW     = (CW_RAW < 1) ? 1 : CW_RAW;
    localparam logic [CW-1:0] ONE    = CW'(1);
    localparam logic [CW-1:0] LIM_M1 =
        CW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_HOLD,
        S_ERR
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [31:0]   r_pc;
    logic [31:0]   r_instr;
    logic [CW-1:0] r_cnt;
    logic          r_err;
    logic          w_commit;
    logic          w_limit;
    logic          w_timeout;
    logic          w_trap;

    assign w_commit  = (r_state == S_HOLD) && instr_ready;
    assign w_limit   = (TIMEOUT_CYCLES != 0) && (r_cnt == LIM_M1);
    assign w_timeout = (r_state == S_WAIT) && !imem_rvalid && w_limit;

`ifdef MISALIGN_TRAP_EN
    logic r_mis;
    assign w_trap = |new_pc[1:0];
`else
    assign w_trap = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  w_next = S_FETCH;
            S_FETCH: if (imem_gnt) w_next = S_WAIT;
            S_WAIT: begin
                if (imem_rvalid) w_next = S_HOLD;
                else if (w_limit) w_next = S_ERR;
            end
            S_HOLD:  if (w_commit) w_next = w_trap ? S_ERR : S_FETCH;
            S_ERR:   w_next = S_ERR;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_pc    <= RESET_PC;
            r_instr <= NOP;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_FETCH && imem_gnt) begin
                r_cnt <= '0;
            end else if (r_state == S_WAIT && !imem_rvalid && r_cnt != '1) begin
                r_cnt <= r_cnt + ONE;
            end
            if (r_state == S_WAIT && imem_rvalid) r_instr <= imem_rdata;
            // Low PC bits are forced to zero; a trapped commit leaves PC untouched
            if (w_commit && !w_trap) r_pc <= new_pc & 32'hFFFF_FFFC;
            r_err <= r_err | w_timeout | (w_commit & w_trap);
        end
    end

`ifdef MISALIGN_TRAP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_mis <= 1'b0;
        else        r_mis <= r_mis | (w_commit & w_trap);
    end
    assign fetch_misaligned = r_mis;
`else
    assign fetch_misaligned = 1'b0;
`endif

    assign imem_req    = (r_state == S_FETCH);
    assign imem_addr   = r_pc;
    assign instr_valid = (r_state == S_HOLD);
    assign instr       = r_instr;
    assign pc          = r_pc;
    assign pc_plus_4   = r_pc + 32'd4;
    assign fetch_err   = r_err;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized fetch traffic with a PC model and a scoreboard monitor.
// Covers reset, grant stall, rvalid at the timeout limit, timeout, wrap and reset mid-fetch.
module tb_fetch_unit;

    localparam logic [31:0] RPC = 32'h0000_0000;
    localparam int TO = 4;
`ifdef MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus_4;
    logic [31:0] new_pc = 32'h0;
    logic        fetch_err;
    logic        fetch_misaligned;

    int checks = 0;
    int errors = 0;
    logic [31:0] m_pc = RPC;
    logic [95:0] exp_q[$];

    fetch_unit #(.RESET_PC(RPC), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .pc(pc), .pc_plus_4(pc_plus_4),
        .new_pc(new_pc), .fetch_err(fetch_err),
        .fetch_misaligned(fetch_misaligned)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Monitor: pop one expectation per instr_valid episode, check every held cycle
    initial begin : monitor
        logic [95:0] cur;
        bit have;
        have = 1'b0;
        cur = '0;
        forever begin
            @(negedge clk);
            if (!rst_n || !instr_valid) begin
                have = 1'b0;
            end else begin
                if (!have) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_instr actual=%h required=none", instr);
                        cur = {instr, pc, pc_plus_4};
                    end else begin
                        cur = exp_q.pop_front();
                    end
                    have = 1'b1;
                end
                chk("instr", instr, cur[95:64]);
                chk("pc", pc, cur[63:32]);
                chk("pc_plus_4", pc_plus_4, cur[31:0]);
            end
        end
    end

    task automatic reset_vals();
        chk("rst_req", 32'(imem_req), 0);
        chk("rst_valid", 32'(instr_valid), 0);
        chk("rst_instr", instr, 32'h0000_0013);
        chk("rst_err", 32'(fetch_err), 0);
        chk("rst_mis", 32'(fetch_misaligned), 0);
        chk("rst_addr", imem_addr, RPC);
        chk("rst_pc4", pc_plus_4, RPC + 32'd4);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        imem_gnt = 1'b0;
        imem_rvalid = 1'b0;
        instr_ready = 1'b0;
        #1;
        @(negedge clk);
        reset_vals();
        exp_q.delete();
        m_pc = RPC;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (imem_req) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL req_timeout actual=0 required=1");
        end
    endtask

    task automatic fetch_grant(input int gdly);
        chk("imem_addr", imem_addr, m_pc);
        for (int i = 0; i < gdly; i++) begin
            @(negedge clk);
            chk("req_held", 32'(imem_req), 1);
            chk("addr_held", imem_addr, m_pc);
            chk("no_valid_fetch", 32'(instr_valid), 0);
        end
        imem_gnt = 1'b1;
        @(negedge clk);
        imem_gnt = 1'b0;
    endtask

    task automatic do_txn(input logic [31:0] data, input int gdly,
                          input int rdly, input logic [31:0] npc,
                          input int cdly);
        bit ok;
        wait_req(ok);
        if (!ok) return;
        fetch_grant(gdly);
        for (int i = 1; i < rdly; i++) begin
            chk("no_req_wait", 32'(imem_req), 0);
            @(negedge clk);
        end
        exp_q.push_back({data, m_pc, m_pc + 32'd4});
        imem_rvalid = 1'b1;
        imem_rdata = data;
        @(negedge clk);
        imem_rvalid = 1'b0;
        imem_rdata = $urandom;
        for (int i = 0; i < cdly; i++) @(negedge clk);
        chk("valid_before_commit", 32'(instr_valid), 1);
        instr_ready = 1'b1;
        new_pc = npc;
        @(negedge clk);
        instr_ready = 1'b0;
        new_pc = $urandom;
        chk("valid_drop", 32'(instr_valid), 0);
        if (!(TRAP && npc[1:0] != 2'b00)) m_pc = npc & 32'hFFFF_FFFC;
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog actual=hang required=finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        bit ok;
        logic [31:0] npc;
        do_reset();
        do_txn(32'h0050_0093, 0, 1, 32'h0000_0040, 0);
        do_txn($urandom, 0, 1, $urandom & 32'hFFFF_FFFC, 1);
        do_txn($urandom, 5, 2, $urandom & 32'hFFFF_FFFC, 0);
        for (int n = 0; n < 30; n++) begin
            npc = $urandom;
            if (TRAP) npc = npc & 32'hFFFF_FFFC;
            do_txn($urandom, $urandom_range(0, 3), $urandom_range(1, TO),
                   npc, $urandom_range(0, 2));
        end
        do_txn($urandom, 0, TO, 32'hFFFF_FFFC, 0);
        do_txn($urandom, 0, 2, 32'h0000_0102, 1);
        if (TRAP) begin
            for (int i = 0; i < 3; i++) begin
                chk("trap_err", 32'(fetch_err), 1);
                chk("trap_mis", 32'(fetch_misaligned), 1);
                chk("trap_no_req", 32'(imem_req), 0);
                @(negedge clk);
            end
            do_reset();
        end else begin
            do_txn($urandom, 0, 1, 32'h0000_0010, 0);
            chk("mis_tied", 32'(fetch_misaligned), 0);
        end

        // Timeout: no rvalid after grant
        wait_req(ok);
        fetch_grant(0);
        for (int i = 1; i <= TO; i++) begin
            chk("err_early", 32'(fetch_err), 0);
            @(negedge clk);
        end
        chk("err_timeout", 32'(fetch_err), 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("err_no_req", 32'(imem_req), 0);
            chk("err_no_valid", 32'(instr_valid), 0);
            chk("err_sticky", 32'(fetch_err), 1);
        end
        do_reset();

        // Reset during WAIT, then a stray rvalid in IDLE and FETCH
        do_txn(32'h1234_5678, 0, 1, 32'h0000_0200, 0);
        wait_req(ok);
        fetch_grant(1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("async_instr", instr, 32'h0000_0013);
        chk("async_pc", pc, RPC);
        do_reset();
        imem_rvalid = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("stray_no_valid", 32'(instr_valid), 0);
        chk("refetch_req", 32'(imem_req), 1);
        chk("refetch_addr", imem_addr, RPC);
        @(negedge clk);
        chk("stray_no_valid2", 32'(instr_valid), 0);
        imem_rvalid = 1'b0;
        do_txn($urandom, $urandom_range(0, 2), $urandom_range(1, TO),
               32'h0000_0080, 0);
        chk("queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
